// File: rtl/contador_primos_pares.sv
// Window statistics stage behind the PRIMOS_PARES classifier.
// Ports: CLK, RST_N, START, SAMPLE, D..A, PRIMOS, PARES in; CNT_*, ULT_PRIMO, BUSY, DONE out.
module contador_primos_pares #(
  parameter int WINDOW = 16,
  parameter int CW     = 5
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic          SAMPLE,
  input  logic          D,
  input  logic          C,
  input  logic          B,
  input  logic          A,
  input  logic          PRIMOS,
  input  logic          PARES,
  output logic [CW-1:0] CNT_PRIMOS,
  output logic [CW-1:0] CNT_PARES,
  output logic [CW-1:0] CNT_AMBOS,
  output logic [3:0]    ULT_PRIMO,
  output logic          BUSY,
  output logic          DONE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t st, st_nx;

  logic          clr;
  logic          acc;
  logic          last;
  logic [3:0]    code;

  logic [CW-1:0] n_q, pri_q, par_q, amb_q;
  logic [3:0]    ult_q;
  logic [CW-1:0] n_nx, pri_nx, par_nx, amb_nx;
  logic [3:0]    ult_nx;

  assign code   = {D, C, B, A};
  assign n_nx   = n_q + CW'(1);
  assign pri_nx = pri_q + CW'(PRIMOS);
  assign par_nx = par_q + CW'(PARES);
  assign amb_nx = amb_q + CW'(PRIMOS & PARES);
  assign ult_nx = PRIMOS ? code : ult_q;
  assign last   = (n_nx == CW'(WINDOW));

  always_comb begin
    st_nx = st;
    clr   = 1'b0;
    acc   = 1'b0;
    unique case (st)
      IDLE: begin
        if (START) begin
          clr   = 1'b1;
          st_nx = RUN;
        end
      end
      RUN: begin
        if (START) begin
          clr = 1'b1;
        end else if (SAMPLE) begin
          acc = 1'b1;
          if (last) st_nx = FIN;
        end
      end
      FIN: begin
        if (START) begin
          clr   = 1'b1;
          st_nx = RUN;
        end else begin
          st_nx = IDLE;
        end
      end
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st   <= IDLE;
      BUSY <= 1'b0;
      DONE <= 1'b0;
    end else begin
      st   <= st_nx;
      BUSY <= (st_nx == RUN);
      DONE <= (st_nx == FIN);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      n_q   <= '0;
      pri_q <= '0;
      par_q <= '0;
      amb_q <= '0;
      ult_q <= '0;
    end else if (clr) begin
      n_q   <= '0;
      pri_q <= '0;
      par_q <= '0;
      amb_q <= '0;
      ult_q <= '0;
    end else if (acc) begin
      n_q   <= n_nx;
      pri_q <= pri_nx;
      par_q <= par_nx;
      amb_q <= amb_nx;
      ult_q <= ult_nx;
    end
  end

  // Results take the working values including the closing sample.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CNT_PRIMOS <= '0;
      CNT_PARES  <= '0;
      CNT_AMBOS  <= '0;
      ULT_PRIMO  <= '0;
    end else if (acc && last) begin
      CNT_PRIMOS <= pri_nx;
      CNT_PARES  <= par_nx;
      CNT_AMBOS  <= amb_nx;
      ULT_PRIMO  <= ult_nx;
    end
  end

endmodule

// File: tb/tb_contador_primos_pares.sv
// Directed bench for contador_primos_pares.
// Table of full windows plus restart, reset and START-in-FIN sequences.
module tb_contador_primos_pares;

  localparam int CW = 5;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          sample;
  logic          d, c, b, a;
  logic          primos;
  logic          pares;
  logic [CW-1:0] cnt_primos;
  logic [CW-1:0] cnt_pares;
  logic [CW-1:0] cnt_ambos;
  logic [3:0]    ult_primo;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  contador_primos_pares #(.WINDOW(16), .CW(CW)) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .START      (start),
    .SAMPLE     (sample),
    .D          (d),
    .C          (c),
    .B          (b),
    .A          (a),
    .PRIMOS     (primos),
    .PARES      (pares),
    .CNT_PRIMOS (cnt_primos),
    .CNT_PARES  (cnt_pares),
    .CNT_AMBOS  (cnt_ambos),
    .ULT_PRIMO  (ult_primo),
    .BUSY       (busy),
    .DONE       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] codes;
    bit          gap;
    int          e_pri;
    int          e_par;
    int          e_amb;
    int          e_ult;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit is_prime(input logic [3:0] v);
    case (v)
      4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_code(input logic [3:0] v);
    {d, c, b, a} = v;
    primos = is_prime(v);
    pares  = ~v[0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_res(input string nm, input int p, input int e,
                         input int m, input int u);
    chk({nm, "_pri"}, int'(cnt_primos), p);
    chk({nm, "_par"}, int'(cnt_pares), e);
    chk({nm, "_amb"}, int'(cnt_ambos), m);
    chk({nm, "_ult"}, int'(ult_primo), u);
  endtask

  // Leaves the bench #1 after the edge accepting sample 16 (FIN).
  task automatic run_window(input logic [63:0] codes, input bit gap,
                            output int busy_cyc);
    logic [63:0] cw;
    cw = codes;
    start  = 1'b1;
    sample = 1'b1;
    set_code(4'd13);
    step();
    start    = 1'b0;
    sample   = 1'b0;
    busy_cyc = 0;
    for (int i = 0; i < 16; i++) begin
      if (gap) begin
        sample = 1'b0;
        busy_cyc += int'(busy);
        step();
      end
      set_code(cw[4*i +: 4]);
      sample = 1'b1;
      busy_cyc += int'(busy);
      if (i == 15) chk("done_early", int'(done), 0);
      step();
    end
    sample = 1'b0;
  endtask

  initial begin
    int bc;
    tbl[0] = '{64'hFEDC_BA98_7654_3210, 1'b0, 6, 8, 1, 13};
    tbl[1] = '{64'h2222_2222_2222_2222, 1'b1, 16, 16, 16, 2};
    tbl[2] = '{64'h8640_8640_8640_8640, 1'b0, 0, 16, 0, 0};
    tbl[3] = '{64'h3333_3333_3333_3333, 1'b0, 16, 0, 0, 3};
    tbl[4] = '{64'h0123_4567_89AB_CDEF, 1'b0, 6, 8, 1, 2};

    rst_n  = 1'b0;
    start  = 1'b0;
    sample = 1'b0;
    set_code(4'd0);
    repeat (3) step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk_res("rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    step();

    for (int t = 0; t < 5; t++) begin
      run_window(tbl[t].codes, tbl[t].gap, bc);
      chk($sformatf("v%0d_runcyc", t), bc, tbl[t].gap ? 32 : 16);
      chk($sformatf("v%0d_done", t), int'(done), 1);
      chk($sformatf("v%0d_busy", t), int'(busy), 0);
      chk_res($sformatf("v%0d", t), tbl[t].e_pri, tbl[t].e_par,
              tbl[t].e_amb, tbl[t].e_ult);
      step();
      chk($sformatf("v%0d_idle_done", t), int'(done), 0);
      chk($sformatf("v%0d_idle_busy", t), int'(busy), 0);
      chk_res($sformatf("v%0d_hold", t), tbl[t].e_pri, tbl[t].e_par,
              tbl[t].e_amb, tbl[t].e_ult);
    end

    // Restart mid-window: 10 samples of 3 discarded, then 16 of 4.
    start = 1'b1;
    step();
    start  = 1'b0;
    sample = 1'b1;
    set_code(4'd3);
    repeat (10) step();
    chk("rs_busy", int'(busy), 1);
    chk_res("rs_mid", 6, 8, 1, 2);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rs_busy2", int'(busy), 1);
    chk("rs_done2", int'(done), 0);
    chk_res("rs_after", 6, 8, 1, 2);
    set_code(4'd4);
    for (int i = 0; i < 16; i++) begin
      step();
      if (i < 15) begin
        chk("rs_nodone", int'(done), 0);
        chk("rs_hold_par", int'(cnt_pares), 8);
      end
    end
    sample = 1'b0;
    chk("rs_done", int'(done), 1);
    chk_res("rs", 0, 16, 0, 0);

    // START held in FIN: straight back to RUN, results kept.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("fs_done", int'(done), 0);
    chk("fs_busy", int'(busy), 1);
    chk_res("fs_hold", 0, 16, 0, 0);
    sample = 1'b1;
    set_code(4'd2);
    repeat (16) step();
    sample = 1'b0;
    chk("fs_done2", int'(done), 1);
    chk_res("fs", 16, 16, 16, 2);
    step();

    // Asynchronous reset in the middle of a window.
    start = 1'b1;
    step();
    start  = 1'b0;
    sample = 1'b1;
    set_code(4'd5);
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", int'(busy), 0);
    chk("ar_done", int'(done), 0);
    chk_res("ar", 0, 0, 0, 0);
    sample = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ar_rel_done", int'(done), 0);
      chk("ar_rel_busy", int'(busy), 0);
    end
    chk_res("ar_rel", 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/contador_primos_pares.md
Name: contador_primos_pares

Overview:
- Downstream stage of the PRIMOS_PARES classifier. Consumes its PRIMOS/PARES flags together with the 4-bit code {D,C,B,A} that fed it.
- Tallies the flags over a window of WINDOW accepted samples, then publishes registered counts, the last prime code seen, and a one-cycle DONE pulse.
- Gives the combinational classifier a sequential statistics/reporting stage for later display logic.

Parameters:
- WINDOW, 16, accepted samples per measurement window; legal range 1..2^CW-1.
- CW, 5, width of all count registers; must hold the value WINDOW.

Ports:
- CLK  input  1  single clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  begin or restart a window; level sampled on each rising edge.
- SAMPLE  input  1  current D,C,B,A,PRIMOS,PARES are valid this cycle.
- D  input  1  code bit 3 (MSB).
- C  input  1  code bit 2.
- B  input  1  code bit 1.
- A  input  1  code bit 0 (LSB).
- PRIMOS  input  1  classifier flag: code is prime.
- PARES  input  1  classifier flag: code is even.
- CNT_PRIMOS  output  CW  prime count of the last completed window.
- CNT_PARES  output  CW  even count of the last completed window.
- CNT_AMBOS  output  CW  count of samples that were both prime and even.
- ULT_PRIMO  output  4  {D,C,B,A} of the last prime sample in the last completed window; 0 if the window had none.
- BUSY  output  1  high while in RUN.
- DONE  output  1  one-cycle pulse: results just updated.

Behaviour:
- Reset (RST_N=0, asynchronous): state IDLE; all working and result registers 0; BUSY=0, DONE=0. Applies immediately, including mid-window. No partial results are published.
- FSM states: IDLE, RUN, FIN. All outputs are registered.
- IDLE:
  - BUSY=0, DONE=0; result outputs hold their values.
  - START=1 at an edge: clear the working counters (samples, primes, evens, both, last prime), go to RUN.
  - SAMPLE in the START cycle is ignored.
- RUN:
  - BUSY=1.
  - Each edge with SAMPLE=1 and START=0:
    - sample count +1;
    - PRIMOS adds 1 to the prime count and loads {D,C,B,A} into the last-prime register;
    - PARES adds 1 to the even count;
    - PRIMOS&PARES adds 1 to the both count.
  - When the accepted sample is number WINDOW, on that same edge:
    - copy the final working values, including this sample, into CNT_PRIMOS, CNT_PARES, CNT_AMBOS, ULT_PRIMO;
    - go to FIN.
  - SAMPLE=0: no change.
  - START=1 in RUN: restart. Clear the working counters, stay in RUN, discard that cycle's sample, leave the result outputs untouched.
- FIN:
  - DONE=1 and BUSY=0 for exactly one cycle. The new results are visible in this same cycle.
  - Next edge: if START=1, clear and go to RUN; otherwise go to IDLE. SAMPLE in FIN is ignored.
- Latency: DONE rises in the cycle after the edge that accepts sample WINDOW.
- Widths and limits:
  - Counts never exceed WINDOW, so there is no overflow.
  - The flags are trusted as given; the block does not re-check primality.
  - CNT_AMBOS ≤ min(CNT_PRIMOS, CNT_PARES).
- Results persist across IDLE and across later START events until the next window completes or reset asserts.

Test Plan:
- WINDOW=16, START, then codes 0..15 with SAMPLE=1 on consecutive cycles, flags driven by the PRIMOS_PARES classifier.
  - -> DONE one cycle after the code-15 edge.
  - -> CNT_PRIMOS=6, CNT_PARES=8, CNT_AMBOS=1, ULT_PRIMO=4'b1101.
  - -> BUSY high for the 16 sampling cycles.
- Code 2 repeated 16 times, with SAMPLE low on every other cycle.
  - -> 32 cycles in RUN.
  - -> CNT_PRIMOS=16, CNT_PARES=16, CNT_AMBOS=16, ULT_PRIMO=2.
- Start a window, send 10 samples of code 3, assert START, then send 16 samples of code 4.
  - -> CNT_PRIMOS=0, CNT_PARES=16, CNT_AMBOS=0, ULT_PRIMO=0.
  - -> Outputs unchanged from the prior window until that DONE.
- Complete a window (results nonzero), start a new one, pull RST_N low after 5 samples.
  - -> All outputs 0 immediately, BUSY=0, and no DONE on reset release.
- Hold START=1 during the FIN cycle.
  - -> DONE pulses once, the next state is RUN with BUSY=1, and the prior results are held.
- Complete a window of codes 0,4,6,8 repeated.
  - -> CNT_PRIMOS=0, CNT_AMBOS=0, ULT_PRIMO=0, CNT_PARES=16.
